// File: rtl/mapu_b_pkg.sv
// Shared types and constants for the 3x3 matrix ADD/MULT response block.
//   state_t : receive / compute / transmit phases of one matrix
//   op_t    : operation select as presented on i_op
//   ROWS    : matrix dimension
//   IN_BEATS: input beats per matrix (A rows then B rows)
package mapu_b_pkg;

  localparam int unsigned ROWS     = 3;
  localparam int unsigned IN_BEATS = 6;

  typedef enum logic [1:0] {
    RX   = 2'd0,
    CALC = 2'd1,
    TX   = 2'd2
  } state_t;

  typedef enum logic {
    ADD  = 1'b0,
    MULT = 1'b1
  } op_t;

  // Full-precision width for one result element: a 3-term sum of
  // DATA_WIDTH x DATA_WIDTH products needs 2*DW + 2 bits.
  function automatic int unsigned full_width(input int unsigned dw);
    return 2 * dw + 2;
  endfunction

endpackage

// File: rtl/mapu_b_row_alu.sv
// One result row of the 3x3 matrix operation.
//   i_op  : ADD (element-wise with B row ROW_IDX) or MULT (A row times B)
//   i_a   : the A row feeding this result row
//   i_b   : the whole B matrix, [row][col]
//   o_r   : result row, truncated to DATA_WIDTH
//   o_of  : 1 if any full-precision element of this row exceeds DATA_WIDTH
module mapu_b_row_alu
  import mapu_b_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ROW_IDX    = 0
) (
  input  op_t                   i_op,
  input  logic [DATA_WIDTH-1:0] i_a [ROWS],
  input  logic [DATA_WIDTH-1:0] i_b [ROWS][ROWS],
  output logic [DATA_WIDTH-1:0] o_r [ROWS],
  output logic                  o_of
);

  localparam int unsigned FW = full_width(DATA_WIDTH);

  always_comb begin : calc
    logic [FW-1:0] w_acc;
    w_acc = '0;
    o_of  = 1'b0;
    for (int unsigned j = 0; j < ROWS; j++) begin
      w_acc = '0;
      if (i_op == ADD) begin
        w_acc = FW'(i_a[j]) + FW'(i_b[ROW_IDX][j]);
      end else begin
        for (int unsigned k = 0; k < ROWS; k++) begin
          w_acc = w_acc + FW'(i_a[k]) * FW'(i_b[k][j]);
        end
      end
      o_r[j] = w_acc[DATA_WIDTH-1:0];
      if (|w_acc[FW-1:DATA_WIDTH]) o_of = 1'b1;
    end
  end

endmodule

// File: rtl/mapu_b_rsp.sv
// 3x3 matrix ADD / MULT engine with row-beat valid/ready streams.
// Receives six row beats (A rows 0-2, then B rows 0-2), computes the full
// result in one cycle, then streams three result rows with an overflow flag.
//   clk, reset_n        : clock, async active-low reset
//   i_en                : permits input acceptance while receiving
//   i_op                : 0 = ADD, 1 = MULT (sampled on beat 0 only)
//   i_vld/i_rdy         : input row handshake
//   i_r0..i_r2          : input row elements
//   o_vld/o_rdy         : output row handshake
//   o_r0..o_r2          : result row elements
//   o_of                : overflow flag for the whole result matrix
module mapu_b_rsp
  import mapu_b_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_en,
  input  logic                  i_op,
  input  logic                  i_vld,
  output logic                  i_rdy,
  input  logic [DATA_WIDTH-1:0] i_r0,
  input  logic [DATA_WIDTH-1:0] i_r1,
  input  logic [DATA_WIDTH-1:0] i_r2,
  output logic                  o_vld,
  input  logic                  o_rdy,
  output logic [DATA_WIDTH-1:0] o_r0,
  output logic [DATA_WIDTH-1:0] o_r1,
  output logic [DATA_WIDTH-1:0] o_r2,
  output logic                  o_of
);

  state_t                r_state;
  logic [2:0]            r_beat;
  logic [1:0]            r_row;
  op_t                   r_op;
  logic                  r_vld;
  logic                  r_of;
  // Received rows in arrival order: [0..2] = A, [3..5] = B.
  logic [DATA_WIDTH-1:0] r_m   [IN_BEATS][ROWS];
  logic [DATA_WIDTH-1:0] r_res [ROWS][ROWS];

  logic [DATA_WIDTH-1:0] w_b   [ROWS][ROWS];
  logic [DATA_WIDTH-1:0] w_res [ROWS][ROWS];
  logic [ROWS-1:0]       w_of;
  logic                  w_in_hs;
  logic                  w_out_hs;

  // Gated by reset_n so i_rdy stays low for the whole reset pulse even
  // though the state already sits in RX.
  assign i_rdy    = reset_n & i_en & (r_state == RX);
  assign w_in_hs  = i_vld & i_rdy;
  assign w_out_hs = r_vld & o_rdy;

  always_comb begin
    for (int unsigned k = 0; k < ROWS; k++) begin
      for (int unsigned j = 0; j < ROWS; j++) begin
        w_b[k][j] = r_m[k + ROWS][j];
      end
    end
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_row
    mapu_b_row_alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROW_IDX    (g)
    ) u_alu (
      .i_op (r_op),
      .i_a  (r_m[g]),
      .i_b  (w_b),
      .o_r  (w_res[g]),
      .o_of (w_of[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RX;
      r_beat  <= '0;
      r_row   <= '0;
      r_op    <= ADD;
      r_vld   <= 1'b0;
      r_of    <= 1'b0;
      for (int unsigned b = 0; b < IN_BEATS; b++) begin
        for (int unsigned j = 0; j < ROWS; j++) r_m[b][j] <= '0;
      end
      for (int unsigned i = 0; i < ROWS; i++) begin
        for (int unsigned j = 0; j < ROWS; j++) r_res[i][j] <= '0;
      end
    end else begin
      case (r_state)
        RX: begin
          if (w_in_hs) begin
            r_m[r_beat][0] <= i_r0;
            r_m[r_beat][1] <= i_r1;
            r_m[r_beat][2] <= i_r2;
            if (r_beat == '0) r_op <= op_t'(i_op);
            if (r_beat == 3'(IN_BEATS - 1)) begin
              r_beat  <= '0;
              r_state <= CALC;
            end else begin
              r_beat <= r_beat + 3'd1;
            end
          end
        end
        CALC: begin
          for (int unsigned i = 0; i < ROWS; i++) begin
            for (int unsigned j = 0; j < ROWS; j++) r_res[i][j] <= w_res[i][j];
          end
          r_of    <= |w_of;
          r_row   <= '0;
          r_vld   <= 1'b1;
          r_state <= TX;
        end
        TX: begin
          if (w_out_hs) begin
            if (r_row == 2'(ROWS - 1)) begin
              r_row   <= '0;
              r_vld   <= 1'b0;
              r_state <= RX;
            end else begin
              r_row <= r_row + 2'd1;
            end
          end
        end
        default: r_state <= RX;
      endcase
    end
  end

  assign o_vld = r_vld;
  assign o_of  = r_of;
  assign o_r0  = r_res[r_row][0];
  assign o_r1  = r_res[r_row][1];
  assign o_r2  = r_res[r_row][2];

endmodule

// File: doc/mapu_b_rsp.md
MAPU_B_RSP -- requirements
Module: mapu_b_rsp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one matrix element.
REQ-002 SHALL have port clk, input, 1: single clock; every flop is on the rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port i_en, input, 1: enables input acceptance.
REQ-005 SHALL have port i_op, input, 1: operation select; 0 = ADD (element-wise), 1 = MULT (matrix product).
REQ-006 SHALL have port i_vld, input, 1: input row beat valid.
REQ-007 SHALL have port i_rdy, output, 1: input row beat ready.
REQ-008 SHALL have ports i_r0, i_r1, i_r2, input, DATA_WIDTH each: input row elements, columns 0..2.
REQ-009 SHALL have port o_vld, output, 1: output row beat valid.
REQ-010 SHALL have port o_rdy, input, 1: output row beat ready.
REQ-011 SHALL have ports o_r0, o_r1, o_r2, output, DATA_WIDTH each: result row elements, columns 0..2.
REQ-012 SHALL have port o_of, output, 1: overflow flag for the current result matrix.

Function
REQ-013 SHALL implement a state machine with three states: RX, CALC and TX.
REQ-014 SHALL accept an input beat only on a cycle where i_vld=1 and i_rdy=1.
REQ-015 SHALL assert i_rdy in RX when i_en=1, and deassert it otherwise; i_rdy SHALL be 0 in CALC and TX.
REQ-016 SHALL interpret the input beats in order: beats 0-2 are matrix A rows 0-2; beats 3-5 are matrix B rows 0-2.
REQ-017 SHALL latch i_op on beat 0 and ignore i_op on beats 1-5.
REQ-018 SHALL, when i_en=0 mid-matrix, hold the beat count and the stored rows; reception resumes when i_en returns to 1.
REQ-019 SHALL move RX->CALC on acceptance of beat 5, CALC->TX after exactly 1 cycle, and TX->RX on acceptance of output row 2.
REQ-020 SHALL register the full 3x3 result and o_of in CALC, so o_vld rises 2 cycles after the beat-5 handshake.
REQ-021 SHALL compute ADD as R[i][j] = A[i][j] + B[i][j], unsigned.
REQ-022 SHALL compute MULT as R[i][j] = sum over k of A[i][k]*B[k][j], unsigned.
REQ-023 SHALL carry full precision internally and truncate each result to its DATA_WIDTH LSBs.
REQ-024 SHALL set o_of=1 if any full-precision result element exceeds 2^DATA_WIDTH-1.
REQ-025 SHALL hold o_of constant for all three output beats of a matrix.
REQ-026 SHALL hold o_vld=1 in TX and present result rows 0, 1, 2 in order, advancing only on o_vld & o_rdy.
REQ-027 SHALL keep o_r0-o_r2 and o_of stable while o_vld=1 and o_rdy=0.
REQ-028 SHALL accept no new input before row 2 is accepted; the block is half-duplex per matrix.
REQ-029 SHALL support back-to-back matrices: i_rdy may rise in the cycle after the row-2 handshake, subject to i_en.

Reset
REQ-030 SHALL, on reset_n=0 in any state, immediately go to RX with beat count 0 and row index 0.
REQ-031 SHALL drive i_rdy=0, o_vld=0, o_of=0 and o_r0-o_r2=0 while reset_n=0.
REQ-032 SHALL discard any partially received or partially transmitted matrix on reset, with no output.
REQ-033 SHALL sample i_en no earlier than the first clock edge after reset_n deasserts.

Structure
REQ-034 SHALL place the state enum (RX/CALC/TX), the op enum (ADD/MULT) and the constants ROWS=3 and IN_BEATS=6 in package mapu_b_pkg.
REQ-035 SHALL use one sub-module, mapu_b_row_alu, instantiated 3 times; each instance computes one result row plus its overflow bit from an A row and all of B.

Verification
REQ-036 SHALL cover ADD: A all 1, B all 2, op=0 -> three rows of (3,3,3), o_of=0, first o_vld 2 cycles after beat 5.
REQ-037 SHALL cover MULT with identity: A = I, B rows (1,2,3),(4,5,6),(7,8,9), op=1 -> output equals B, o_of=0.
REQ-038 SHALL cover overflow: DATA_WIDTH=32, op=0, A[0][0]=0xFFFFFFFF, B[0][0]=1, others 0 -> row 0 = (0,0,0), o_of=1 on all three beats.
REQ-039 SHALL cover backpressure: o_rdy=0 for 5 cycles on row 1 -> row 1 values held stable, no row skipped, and i_rdy=0 throughout.
REQ-040 SHALL cover i_en dropped after beat 2 for 4 cycles -> i_rdy=0 during the gap, then beats 3-5 accepted and the result is correct.
REQ-041 SHALL cover reset asserted during TX row 1 -> o_vld=0 immediately; the next 6 beats produce a fresh, correct result.
